// File: rtl/mem_dma_pkg.sv
// Shared types and constants for the byte-stream <-> 16-bit memory DMA packer.
// Optional feature macro used by the block: MEM_DMA_BYTE_SWAP_EN.
package mem_dma_pkg;

  localparam int MEM_ADDR_W = 27;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    MEM_REQ  = 3'd2,
    MEM_WAIT = 3'd3,
    EMIT     = 3'd4
  } e_dma_state;

  // Lanes a read request needs: an odd start uses only the low lane; an even
  // start uses the high lane, plus the low lane when another byte follows.
  function automatic logic [1:0] read_lanes(input logic odd_i, input logic more_i);
    if (odd_i) return 2'b01;
    return more_i ? 2'b11 : 2'b10;
  endfunction

endpackage

// File: rtl/mem_dma_lane_packer.sv
// Byte <-> 16-bit word lane logic for the DMA packer. Big-endian lanes: the
// even-address byte lives in [15:8] (mask bit 1), the odd one in [7:0] (mask
// bit 0). swap_i exchanges the lanes on the memory side only (both data and
// mask), so the internal word is always in big-endian form.
module mem_dma_lane_packer (
  input  logic        swap_i,
  input  logic        lane_i,
  input  logic [7:0]  byte_i,
  input  logic [15:0] word_i,
  input  logic [1:0]  mask_i,
  output logic [15:0] word_o,
  output logic [1:0]  mask_o,
  output logic [15:0] mem_wdata_o,
  output logic [1:0]  mem_wmask_o,
  input  logic [15:0] mem_rdata_i,
  output logic [15:0] rdata_o,
  input  logic [15:0] rword_i,
  output logic [7:0]  byte_o
);

  // Merge the incoming byte into the lane selected by the address LSB.
  always_comb begin
    word_o = word_i;
    mask_o = mask_i;
    if (lane_i) begin
      word_o[7:0] = byte_i;
      mask_o[0]   = 1'b1;
    end else begin
      word_o[15:8] = byte_i;
      mask_o[1]    = 1'b1;
    end
  end

  assign mem_wdata_o = swap_i ? {word_i[7:0], word_i[15:8]} : word_i;
  assign mem_wmask_o = swap_i ? {mask_i[0], mask_i[1]} : mask_i;
  assign rdata_o     = swap_i ? {mem_rdata_i[7:0], mem_rdata_i[15:8]} : mem_rdata_i;
  assign byte_o      = lane_i ? rword_i[7:0] : rword_i[15:8];

endmodule

// File: rtl/mem_dma_packer.sv
// DMA engine moving bytes between rx/tx byte FIFOs and a 16-bit memory port.
// The mem_* signals carry the mem_bus controller-side names so a wrapper can
// bind them straight onto a mem_bus.controller modport (usb/sd arbiters).
// Optional: MEM_DMA_BYTE_SWAP_EN adds input byte_swap (sampled on start).
// Memory handshake: mem_request rises with address/write/mask/data stable and
// holds them until the cycle mem_ack is high; mem_request drops the next cycle.
module mem_dma_packer
  import mem_dma_pkg::*;
#(
  parameter int LEN_W = 27
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  direction,
  input  logic [MEM_ADDR_W-1:0] starting_address,
  input  logic [LEN_W-1:0]      transfer_length,
`ifdef MEM_DMA_BYTE_SWAP_EN
  input  logic                  byte_swap,
`endif
  output logic                  busy,
  input  logic                  rx_empty,
  output logic                  rx_read,
  input  logic [7:0]            rx_rdata,
  input  logic                  tx_full,
  output logic                  tx_write,
  output logic [7:0]            tx_wdata,
  output logic                  mem_request,
  input  logic                  mem_ack,
  output logic                  mem_write,
  output logic [MEM_ADDR_W-1:0] mem_address,
  output logic [1:0]            mem_wmask,
  output logic [15:0]           mem_wdata,
  input  logic [15:0]           mem_rdata,
  output e_dma_state            dbg_state_o
);

  e_dma_state            state_q, state_d;
  logic [MEM_ADDR_W-1:0] addr_q, addr_d, waddr_q, waddr_d, next_addr;
  logic [LEN_W-1:0]      rem_q, rem_d;
  logic                  dir_q, dir_d, swap_q, swap_d;
  logic                  pend_q, pend_d, stop_pend_q, stop_pend_d;
  logic [15:0]           wword_q, wword_d, rword_q, rword_d;
  logic [1:0]            mask_q, mask_d;
  logic [15:0]           packed_word, rdata_log;
  logic [1:0]            packed_mask;
  logic [7:0]            emit_byte;

  mem_dma_lane_packer u_lanes (
    .swap_i      (swap_q),
    .lane_i      (addr_q[0]),
    .byte_i      (rx_rdata),
    .word_i      (wword_q),
    .mask_i      (mask_q),
    .word_o      (packed_word),
    .mask_o      (packed_mask),
    .mem_wdata_o (mem_wdata),
    .mem_wmask_o (mem_wmask),
    .mem_rdata_i (mem_rdata),
    .rdata_o     (rdata_log),
    .rword_i     (rword_q),
    .byte_o      (emit_byte)
  );

  assign busy        = (state_q != IDLE);
  assign mem_request = (state_q == MEM_REQ) || (state_q == MEM_WAIT);
  assign mem_write   = dir_q;
  assign mem_address = waddr_q;
  assign tx_wdata    = emit_byte;
  assign dbg_state_o = state_q;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state, FIFO strobes and datapath updates.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    dir_d       = dir_q;
    swap_d      = swap_q;
    pend_d      = pend_q;
    stop_pend_d = stop_pend_q;
    wword_d     = wword_q;
    mask_d      = mask_q;
    waddr_d     = waddr_q;
    rword_d     = rword_q;
    next_addr   = addr_q + MEM_ADDR_W'(1);
    rx_read     = 1'b0;
    tx_write    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !stop && (transfer_length != '0)) begin
          addr_d      = starting_address;
          rem_d       = transfer_length;
          dir_d       = direction;
`ifdef MEM_DMA_BYTE_SWAP_EN
          swap_d      = byte_swap;
`else
          swap_d      = 1'b0;
`endif
          pend_d      = 1'b0;
          stop_pend_d = 1'b0;
          wword_d     = '0;
          mask_d      = '0;
          waddr_d     = {starting_address[MEM_ADDR_W-1:1], 1'b0};
          if (direction) begin
            state_d = FETCH;
          end else begin
            state_d = MEM_REQ;
            mask_d  = read_lanes(starting_address[0], transfer_length != LEN_W'(1));
          end
        end
      end
      FETCH: begin
        if (stop) begin
          state_d = IDLE;
          pend_d  = 1'b0;
        end else if (pend_q) begin
          // Byte requested last cycle is on rx_rdata now.
          pend_d  = 1'b0;
          wword_d = packed_word;
          mask_d  = packed_mask;
          waddr_d = {addr_q[MEM_ADDR_W-1:1], 1'b0};
          addr_d  = next_addr;
          rem_d   = rem_q - LEN_W'(1);
          if (addr_q[0] || (rem_q == LEN_W'(1))) state_d = MEM_REQ;
        end else if (!rx_empty) begin
          rx_read = 1'b1;
          pend_d  = 1'b1;
        end
      end
      MEM_REQ, MEM_WAIT: begin
        if (stop) stop_pend_d = 1'b1;
        if (mem_ack) begin
          if (stop_pend_q || stop) begin
            state_d = IDLE;
          end else if (dir_q) begin
            if (rem_q == '0) begin
              state_d = IDLE;
            end else begin
              state_d = FETCH;
              wword_d = '0;
              mask_d  = '0;
            end
          end else begin
            rword_d = rdata_log;
            state_d = EMIT;
          end
        end else begin
          state_d = MEM_WAIT;
        end
      end
      EMIT: begin
        if (stop) begin
          state_d = IDLE;
        end else if (!tx_full) begin
          tx_write = 1'b1;
          addr_d   = next_addr;
          rem_d    = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d = IDLE;
          end else if (addr_q[0]) begin
            state_d = MEM_REQ;
            waddr_d = {next_addr[MEM_ADDR_W-1:1], 1'b0};
            mask_d  = read_lanes(next_addr[0], rem_q > LEN_W'(2));
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath registers; all memory-side and tx outputs derive from these.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      addr_q      <= '0;
      rem_q       <= '0;
      dir_q       <= 1'b0;
      swap_q      <= 1'b0;
      pend_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      wword_q     <= '0;
      mask_q      <= '0;
      waddr_q     <= '0;
      rword_q     <= '0;
    end else begin
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      dir_q       <= dir_d;
      swap_q      <= swap_d;
      pend_q      <= pend_d;
      stop_pend_q <= stop_pend_d;
      wword_q     <= wword_d;
      mask_q      <= mask_d;
      waddr_q     <= waddr_d;
      rword_q     <= rword_d;
    end
  end

endmodule

// File: doc/mem_dma_packer.md
MEM_DMA_PACKER -- requirements
Module: mem_dma_packer

Interface
- REQ-001 SHALL have parameter LEN_W, default 27, meaning the transfer length counter width in bytes.
- REQ-002 SHALL have port clk, input, 1, the single clock.
- REQ-003 SHALL have port reset_n, input, 1, the reset: synchronous, active-low.
- REQ-004 SHALL have port start, input, 1, a one-cycle pulse that launches a transfer.
- REQ-005 SHALL have port stop, input, 1, a one-cycle pulse that aborts a transfer.
- REQ-006 SHALL have port direction, input, 1: 1 = rx FIFO to memory (write), 0 = memory to tx FIFO (read).
- REQ-007 SHALL have port starting_address, input, 27, the byte address sampled on start.
- REQ-008 SHALL have port transfer_length, input, LEN_W, the byte count sampled on start.
- REQ-009 SHALL have port busy, output, 1, asserted while a transfer is active.
- REQ-010 SHALL have ports rx_empty input 1, rx_read output 1 and rx_rdata input 8, the byte FIFO read side; data is valid the cycle after rx_read.
- REQ-011 SHALL have ports tx_full input 1, tx_write output 1 and tx_wdata output 8, the byte FIFO write side.
- REQ-012 SHALL have ports mem_request out 1, mem_ack in 1, mem_write out 1, mem_address out 27, mem_wmask out 2, mem_wdata out 16 and mem_rdata in 16, the memory controller port.
- REQ-013 SHALL connect mem_request, mem_write, mem_address, mem_wmask, mem_wdata and mem_rdata as a mem_bus.controller port, so that the block can drive an arbiter source such as usb_dma_bus or sd_dma_bus.

Function
- REQ-014 SHALL map bytes big-endian: the even-address byte goes on bits [15:8] with wmask[1]; the odd-address byte goes on bits [7:0] with wmask[0].
- REQ-015 SHALL implement the states IDLE, FETCH, MEM_REQ, MEM_WAIT and EMIT.
- REQ-016 SHALL, on start in IDLE with transfer_length != 0, latch address and length, assert busy on the next cycle and enter FETCH (write) or MEM_REQ (read).
- REQ-017 SHALL ignore start when transfer_length == 0 or when busy is asserted.
- REQ-018 SHALL, in FETCH, pulse rx_read only when rx_empty is 0 and at most once per byte, placing each byte into its address-selected lane.
- REQ-019 SHALL leave FETCH for MEM_REQ when the word is complete, i.e. an odd-address byte has been taken or the remaining count has reached 0.
- REQ-020 SHALL, in MEM_REQ, drive mem_request high with the word address (address[0] forced to 0), mem_write set to direction and wmask limited to the lanes actually filled.
- REQ-021 SHALL hold mem_request and all mem_* outputs stable until the cycle mem_ack is high, then drop mem_request on the next cycle.
- REQ-022 SHALL, on a read-transfer ack, capture mem_rdata and enter EMIT.
- REQ-023 SHALL, in EMIT, write the selected lanes to the tx FIFO one byte per cycle, issuing tx_write only while tx_full is 0.
- REQ-024 SHALL decrement the remaining-byte counter once per byte moved and advance the address by 1 per byte.
- REQ-025 SHALL, when the counter reaches 0 after the last memory ack or last EMIT byte, return to IDLE and deassert busy on the next cycle.
- REQ-026 SHALL have stop take priority over a simultaneous start.
- REQ-027 SHALL, on stop in FETCH or EMIT, go to IDLE immediately and discard the partial word.
- REQ-028 SHALL, on stop in MEM_REQ or MEM_WAIT, complete the outstanding request up to mem_ack, then go to IDLE with no further bytes moved.
- REQ-029 SHALL wrap the address modulo 2^27 at the top of the address space.

Reset
- REQ-030 SHALL, while reset_n is 0 at a clock edge, put the block in IDLE with busy, mem_request, rx_read and tx_write all 0, even if reset occurs mid-request.
- REQ-031 SHALL reset mem_address, mem_wdata, mem_wmask and tx_wdata to 0.

Configuration
- REQ-032 SHALL, when MEM_DMA_BYTE_SWAP_EN is defined, add input byte_swap (1 bit, sampled on start) that exchanges the two lanes of mem_wdata and of captured mem_rdata, with the wmask bits swapped to match.
- REQ-033 SHALL, when MEM_DMA_BYTE_SWAP_EN is undefined, have no byte_swap port and use the lane mapping of REQ-014 only.

Structure
- REQ-034 SHALL define the state enum e_dma_state and the constant MEM_ADDR_W=27 in the shared package mem_dma_pkg.
- REQ-035 SHALL contain one sub-module, mem_dma_lane_packer, holding the byte-to-word and word-to-byte lane logic plus the wmask generation.

Verification
- REQ-036 SHALL cover: write, address 0x100, length 4, bytes 11 22 33 44 -> 2 requests: 0x100 data 0x1122 wmask 11, then 0x102 data 0x3344 wmask 11; busy drops after the second ack.
- REQ-037 SHALL cover: write, address 0x101, length 2, bytes AA BB -> request 0x100 wmask 01 data xxAA, then request 0x102 wmask 10 data BBxx.
- REQ-038 SHALL cover: read, address 0x203, length 3, mem_rdata 0x1234 then 0x5678 -> tx bytes 34 56 78, with tx_full held high for 5 cycles stalling without loss.
- REQ-039 SHALL cover: stop during MEM_WAIT with ack delayed 6 cycles -> mem_request stays high until ack, then IDLE with no extra tx_write or rx_read.
- REQ-040 SHALL cover: reset_n low while mem_request is high -> mem_request 0 and busy 0 on the next cycle; start with length 0 -> busy stays 0.
- REQ-041 SHALL cover: address 0x7FFFFFF, length 2, write -> second request at 0x0000000 wmask 10.
